// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  localparam int DIV_N     = 8;
  localparam int DIV_CNT_W = $clog2(DIV_N + 1);

  function automatic int div_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/n_subtractor.sv
// Combinational W-bit subtractor, diff = x + ~y + 1, borrow when x < y.
module n_subtractor #(
  parameter int W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic carry;

  assign {carry, diff} = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
  assign borrow        = ~carry;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_DET_EN to add the div_zero port and the single-cycle divide-by-zero shortcut.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start; results from the last division held
// ST_RUN  | shifting/trial-subtracting, one quotient bit per cycle
// ST_DONE | done pulse; a start here launches the next division
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
`ifdef DIV_ZERO_DET_EN
  ,
  output logic         div_zero
`endif
);

  localparam int CNT_W = div_cnt_width(N);

  div_state_t       state_q, state_d;
  logic [N-1:0]     rem_q, quo_q, div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N:0]       r_shift, trial;
  logic             borrow;
  logic [N-1:0]     rem_nxt, quo_nxt;
  logic             accept, last_step, det_zero;
  logic             unused_trial_msb;

  // Partial remainder stays below the divisor, so its top bit is always zero and not stored.
  assign r_shift = {rem_q, quo_q[N-1]};

  n_subtractor #(.W(N + 1)) u_sub (
    .x      (r_shift),
    .y      ({1'b0, div_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  assign rem_nxt          = borrow ? r_shift[N-1:0] : trial[N-1:0];
  assign quo_nxt          = {quo_q[N-2:0], ~borrow};
  assign unused_trial_msb = trial[N];

`ifdef DIV_ZERO_DET_EN
  assign det_zero = (B == '0);
`else
  assign det_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done    = (state_q == ST_DONE);
        state_d = ST_IDLE;
        if (start) begin
          accept  = 1'b1;
          state_d = det_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          last_step = 1'b1;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Results load on the final step so they are already valid during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      rem_q <= '0;
      quo_q <= A;
      div_q <= B;
      cnt_q <= CNT_W'(N);
      if (det_zero) begin
        quotient  <= '1;
        remainder <= A;
      end
    end else if (state_q == ST_RUN) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - CNT_W'(1);
      if (last_step) begin
        quotient  <= quo_nxt;
        remainder <= rem_nxt;
      end
    end
  end

`ifdef DIV_ZERO_DET_EN
  always_ff @(posedge clk) begin
    if (rst)                      div_zero <= 1'b0;
    else if (accept && det_zero)  div_zero <= 1'b1;
    else if (last_step)           div_zero <= 1'b0;
  end
`endif

endmodule
